// File: rtl/dequant_lane_feeder_pkg.sv
// rtl/dequant_lane_feeder_pkg.sv - shared widths and lane types for the adder tree and its dequant feeder
//
// Purpose: constants shared by the requantizing adder tree and the
// dequant lane feeder, plus the lane-array type and the collect-bank state.
// Ports: none (package).
package dequant_lane_feeder_pkg;

  localparam int DATA_W         = 8;
  localparam int ACC_W          = 32;
  localparam int LANES          = 4;
  localparam int DEF_FRAC_SHIFT = 7;
  localparam int IDX_W          = $clog2(LANES);

  typedef logic signed [ACC_W-1:0] lane_t [LANES];

  typedef enum logic {
    C_FILL = 1'b0,
    C_FULL = 1'b1
  } c_state_t;

endpackage

// File: rtl/dequant8to32.sv
// rtl/dequant8to32.sv - combinational int8 {sign, magnitude} to 32-bit fixed-point expansion
//
// Purpose: place the 7 magnitude bits back at the requantizer slice position
// and fill everything above with the sign bit; optionally set the half-step
// bit below the slice for mid-step reconstruction.
// Ports:
//   q   in  DATA_W  quantized byte {s, m[6:0]}
//   op  out ACC_W   signed expanded operand
module dequant8to32
  import dequant_lane_feeder_pkg::*;
#(
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int ROUND_BIAS = 0
) (
  input  logic        [DATA_W-1:0] q,
  output logic signed [ACC_W-1:0]  op
);

  localparam logic [ACC_W-1:0] BIAS =
    (ROUND_BIAS != 0) ? (ACC_W'(1) << (FRAC_SHIFT - 1)) : '0;

  assign op = $signed({{(ACC_W - FRAC_SHIFT - DATA_W + 1){q[DATA_W-1]}},
                       q[DATA_W-2:0],
                       {FRAC_SHIFT{1'b0}}} | BIAS);

endmodule

// File: rtl/dequant_lane_feeder.sv
// rtl/dequant_lane_feeder.sv - packs expanded int8 activations into 4-lane beats for the adder tree
//
// Purpose: expand each accepted byte, collect four operands (or fewer when
// in_last closes the group early) in bank C, then hand the group to output
// bank O. Two banks let intake continue while a beat waits downstream.
// Ports:
//   clk        in   1      clock
//   rst_n      in   1      synchronous reset, active high
//   in_valid   in   1      in_data presented
//   in_ready   out  1      byte accepted when in_valid && in_ready
//   in_data    in   8      quantized byte {s, m[6:0]}
//   in_last    in   1      closes the current group
//   out_valid  out  1      out1..out4 hold a packed beat
//   out_ready  in   1      downstream takes the beat
//   out1..4    out  32     lane operands, lane 1 = first byte
//   out_last   out  1      beat closed by in_last
//   out_count  out  3      real lanes in the beat, 1..4
module dequant_lane_feeder
  import dequant_lane_feeder_pkg::*;
#(
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int ROUND_BIAS = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic        [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0] out1,
  output logic signed [ACC_W-1:0] out2,
  output logic signed [ACC_W-1:0] out3,
  output logic signed [ACC_W-1:0] out4,
  output logic                     out_last,
  output logic        [2:0]        out_count
);

  logic signed [ACC_W-1:0] exp_op;

  dequant8to32 #(
    .FRAC_SHIFT(FRAC_SHIFT),
    .ROUND_BIAS(ROUND_BIAS)
  ) u_expand (
    .q (in_data),
    .op(exp_op)
  );

  c_state_t         c_state;
  lane_t            c_lane;
  lane_t            o_lane;
  logic [IDX_W-1:0] c_idx;
  logic [2:0]       c_count;
  logic             c_last;

  logic             xfer;
  logic             accept;
  logic [IDX_W-1:0] wr_idx;

  assign xfer     = (c_state == C_FULL) && (!out_valid || out_ready);
  // Equivalent to !(C full && O held): whenever C is full and input is
  // allowed, a transfer empties C in the same cycle.
  assign in_ready = (c_state == C_FILL) || xfer;
  assign accept   = in_valid && in_ready;
  // A byte accepted alongside a transfer starts the next group at lane 0.
  assign wr_idx   = xfer ? '0 : c_idx;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      c_state   <= C_FILL;
      c_idx     <= '0;
      c_count   <= '0;
      c_last    <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_count <= '0;
      for (int i = 0; i < LANES; i++) begin
        c_lane[i] <= '0;
        o_lane[i] <= '0;
      end
    end else begin
      if (xfer) begin
        o_lane    <= c_lane;
        out_valid <= 1'b1;
        out_last  <= c_last;
        out_count <= c_count;
        c_state   <= C_FILL;
        c_idx     <= '0;
        c_count   <= '0;
        c_last    <= 1'b0;
        for (int i = 0; i < LANES; i++) begin
          c_lane[i] <= '0;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Lane write comes after the clear so a same-cycle byte survives it.
      if (accept) begin
        c_lane[wr_idx] <= exp_op;
        if (wr_idx == IDX_W'(LANES - 1) || in_last) begin
          c_state <= C_FULL;
          c_last  <= in_last;
          c_count <= {1'b0, wr_idx} + 3'd1;
          c_idx   <= '0;
        end else begin
          c_idx <= wr_idx + IDX_W'(1);
        end
      end
    end
  end

  assign out1 = o_lane[0];
  assign out2 = o_lane[1];
  assign out3 = o_lane[2];
  assign out4 = o_lane[3];

endmodule

// File: tb/tb_dequant_lane_feeder.sv
// tb/tb_dequant_lane_feeder.sv - self-checking bench for dequant_lane_feeder
module tb_dequant_lane_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out1, out2, out3, out4;
  logic [2:0]  out_count;

  logic        b_in_valid, b_in_ready, b_in_last;
  logic [7:0]  b_in_data;
  logic        b_out_valid, b_out_ready, b_out_last;
  logic [31:0] b_out1, b_out2, b_out3, b_out4;
  logic [2:0]  b_out_count;

  always #5 clk = ~clk;

  dequant_lane_feeder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .out_last(out_last), .out_count(out_count)
  );

  dequant_lane_feeder #(.FRAC_SHIFT(7), .ROUND_BIAS(1)) dut_rb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out1(b_out1), .out2(b_out2), .out3(b_out3), .out4(b_out4),
    .out_last(b_out_last), .out_count(b_out_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: value = sign * 2^14 offset + magnitude * 2^7 (+ half step)
  function automatic logic [31:0] model_op(input logic [7:0] d, input bit rb);
    int v;
    v = int'(d[6:0]) * 128;
    if (d[7]) v = v - 16384;
    if (rb) v = v + 64;
    return 32'(v);
  endfunction

  typedef struct {
    logic [0:3][31:0] lane;
    int               cnt;
    bit               last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] cur[$];
  int          beats_seen = 0;
  bit          hold_pend = 0;
  logic [130:0] hold_snap;

  always @(negedge clk) begin
    beat_t b;
    if (rst_n) begin
      cur.delete();
      exp_q.delete();
      hold_pend = 0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_beat", {out1, out2, out3, out4, out_count}, hold_snap[130:1]);
        check("hold_last", out_last, hold_snap[0]);
      end
      hold_pend = out_valid && !out_ready;
      hold_snap = {out1, out2, out3, out4, out_count, out_last};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          b = exp_q.pop_front();
          check("beat_lanes", {out1, out2, out3, out4}, b.lane);
          check("beat_count", out_count, b.cnt);
          check("beat_last", out_last, b.last);
        end
        beats_seen++;
      end
      if (in_valid && in_ready) begin
        cur.push_back(model_op(in_data, 0));
        if (cur.size() == 4 || in_last) begin
          b.lane = '0;
          for (int i = 0; i < cur.size(); i++) b.lane[i] = cur[i];
          b.cnt  = cur.size();
          b.last = in_last;
          exp_q.push_back(b);
          cur.delete();
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit last);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && (exp_q.size() != 0 || out_valid); k++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input logic [31:0] e1, e2, e3, e4,
                             input int cnt, input bit lst, input int lat);
    int n = 0;
    bit found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      n++;
      found = out_valid;
    end
    check("beat_found", found, 1'b1);
    check("latency", n, lat);
    check("dir_lanes", {out1, out2, out3, out4}, {e1, e2, e3, e4});
    check("dir_count", out_count, cnt);
    check("dir_last", out_last, lst);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          b0;
    logic [7:0]  d9, bb0;
    bit          acc, found;

    rst_n = 1'b1;
    in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    b_in_valid = 0; b_in_data = 0; b_in_last = 0; b_out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_count", out_count, 3'd0);
    check("rst_lanes", {out1, out2, out3, out4}, 128'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Full beat, mixed signs
    out_ready = 1;
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h81, 0); send_byte(8'hFF, 0);
    expect_beat(32'h00000080, 32'h00000100, 32'hFFFFC080, 32'hFFFFFF80, 4, 0, 2);

    // Partial group closed by in_last
    send_byte(8'h7F, 0); send_byte(8'h80, 1);
    expect_beat(32'h00003F80, 32'hFFFFC000, 32'h0, 32'h0, 2, 1, 2);
    wait_drain();

    // Both banks occupied -> backpressure
    b0 = beats_seen;
    out_ready = 0;
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
    d9 = 8'($urandom);
    in_valid = 1; in_data = d9; in_last = 0;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    send_byte(d9, 0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
    wait_drain();
    check("stall_beats", beats_seen - b0, 3);

    // Same-cycle transfer and accept
    out_ready = 0;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    bb0 = 8'($urandom);
    send_byte(bb0, 0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
    out_ready = 1;
    in_valid = 1; in_data = 8'($urandom); in_last = 0;
    @(negedge clk);
    check("same_cycle_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 0;
    out_ready = 0;
    check("same_cycle_xfer_valid", out_valid, 1'b1);
    check("same_cycle_xfer_out1", out1, model_op(bb0, 0));
    out_ready = 1;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
    wait_drain();

    // Reset mid-group
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_lanes", {out1, out2, out3, out4}, 128'd0);
    check("midrst_count", out_count, 3'd0);
    rst_n = 0;
    b0 = beats_seen;
    send_byte(8'h05, 0); send_byte(8'h86, 0); send_byte(8'h07, 0); send_byte(8'h88, 0);
    wait_drain();
    check("midrst_beats", beats_seen - b0, 1);

    // Mid-step reconstruction instance
    b_in_valid = 1; b_in_data = 8'h00; b_in_last = 1;
    @(negedge clk);
    check("rb_ready", b_in_ready, 1'b1);
    @(posedge clk);
    #1;
    b_in_valid = 0; b_in_last = 0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      found = b_out_valid;
    end
    check("rb_found", found, 1'b1);
    check("rb_out1", b_out1, 32'h00000040);
    check("rb_rest", {b_out2, b_out3, b_out4}, 96'd0);
    check("rb_count", b_out_count, 3'd1);
    check("rb_last", b_out_last, 1'b1);
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure and gaps
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom % 4) != 0;
        in_data  = 8'($urandom);
        in_last  = ($urandom % 6) == 0;
      end
      out_ready = ($urandom % 3) != 0;
    end
    out_ready = 1;
    send_byte(8'($urandom), 1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
